// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: oversampled START/STOP decode, 7-bit address match, byte write/read
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_addr_match,
    output logic       o_rw,
    output logic [7:0] o_rx_data,
    output logic       o_rx_dv,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_err
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   load_pending;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_cond, stop_cond;
    logic [7:0] tx_byte;

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_q;
    assign scl_fall   = ~scl_s & scl_q;
    assign sda_rise   = sda_s & ~sda_q;
    assign sda_fall   = ~sda_s & sda_q;
    assign start_cond = sda_fall & scl_s & scl_q;
    assign stop_cond  = sda_rise & scl_s & scl_q;
    // An empty user side puts all-ones on the bus, which reads as an idle line.
    assign tx_byte    = i_tx_valid ? i_tx_data : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            load_pending <= 1'b0;
            o_sda_oe     <= 1'b0;
            o_busy       <= 1'b0;
            o_addr_match <= 1'b0;
            o_rw         <= 1'b0;
            o_rx_data    <= 8'h00;
            o_rx_dv      <= 1'b0;
            o_tx_req     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_rx_dv  <= 1'b0;
            o_tx_req <= 1'b0;
            o_err    <= 1'b0;
            if (start_cond) begin
                state        <= ADDR;
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
                o_busy       <= 1'b1;
                o_addr_match <= 1'b0;
                o_sda_oe     <= 1'b0;
            end else if (stop_cond) begin
                state        <= IDLE;
                load_pending <= 1'b0;
                o_busy       <= 1'b0;
                o_addr_match <= 1'b0;
                o_sda_oe     <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shreg[6:0] == TARGET_ADDR) begin
                                o_addr_match <= 1'b1;
                                o_rw         <= sda_s;
                                o_tx_req     <= sda_s;
                                state        <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    // First scl_fall starts the ACK, the second ends it.
                    ADDR_ACK: if (scl_fall) begin
                        if (!o_sda_oe) begin
                            o_sda_oe <= 1'b1;
                        end else if (o_rw) begin
                            shreg    <= tx_byte;
                            o_sda_oe <= ~tx_byte[7];
                            o_err    <= ~i_tx_valid;
                            bit_cnt  <= 3'd0;
                            state    <= RD_DATA;
                        end else begin
                            o_sda_oe <= 1'b0;
                            state    <= WR_DATA;
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            o_rx_data <= {shreg[6:0], sda_s};
                            o_rx_dv   <= 1'b1;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!o_sda_oe) begin
                            o_sda_oe <= 1'b1;
                        end else begin
                            o_sda_oe <= 1'b0;
                            state    <= WR_DATA;
                        end
                    end
                    RD_DATA: if (scl_fall) begin
                        if (load_pending) begin
                            load_pending <= 1'b0;
                            shreg        <= tx_byte;
                            o_sda_oe     <= ~tx_byte[7];
                            o_err        <= ~i_tx_valid;
                            bit_cnt      <= 3'd0;
                        end else if (bit_cnt == 3'd7) begin
                            o_sda_oe <= 1'b0;
                            bit_cnt  <= 3'd0;
                            state    <= RD_ACK;
                        end else begin
                            shreg    <= {shreg[6:0], 1'b0};
                            o_sda_oe <= ~shreg[6];
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (!sda_s) begin
                            o_tx_req     <= 1'b1;
                            load_pending <= 1'b1;
                            state        <= RD_DATA;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    IDLE, WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
